nonce_result_fifo: RTL and testbench
====================================

NONCE_RESULT_FIFO -- requirements
Module: nonce_result_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 Parameter ADDR_BASE, default 32'h3000_0100, Wishbone base address of the register window.
REQ-003 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 wb_rst_n  input  1  reset, synchronous, active-low.
REQ-005 nonce_valid_i  input  1  one-cycle strobe from hash core: golden nonce found.
REQ-006 nonce_i  input  32  nonce value, qualified by nonce_valid_i.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-008 wbs_sel_i  input  4  byte selects; ignored, full-word access only.
REQ-009 wbs_adr_i  input  32  byte address.
REQ-010 wbs_dat_i  input  32  write data.
REQ-011 wbs_ack_o  output  1  transfer acknowledge.
REQ-012 wbs_dat_o  output  32  read data.
REQ-013 status_o  output  16  pad-visible status to mprj_io[31:16]: {overflow, full, empty, 8'h00, count[4:0]}.
REQ-014 irq_o  output  1  level interrupt to management core.

Function
REQ-015 Registers: ADDR_BASE+0 DATA (R), +4 STATUS (R/W), +8 CTRL (R/W); other addresses in window [ADDR_BASE, ADDR_BASE+0xFF] ack with read data 0, writes ignored; addresses outside window never ack.
REQ-016 Access accepted when cyc&stb&~ack and address in window; wbs_ack_o high exactly one cycle, the cycle after acceptance; back-to-back accesses therefore take 2 cycles each.
REQ-017 wbs_dat_o valid while wbs_ack_o high, 0 otherwise.
REQ-018 DATA read returns head entry and pops it in the ack cycle; DATA read when empty returns 32'h0000_0000, no pop, no state change.
REQ-019 STATUS read: bit31 overflow, bit30 full, bit29 empty, bits[4:0] count (0..DEPTH), rest 0.
REQ-020 STATUS write with wbs_dat_i[31]=1 clears overflow; with bit0=1 flushes FIFO (count 0, pointers 0); other bits ignored.
REQ-021 nonce_valid_i with count<DEPTH: nonce_i written at tail, count+1 next cycle; latency push->visible in STATUS/DATA = 1 cycle.
REQ-022 nonce_valid_i with count==DEPTH and no pop same cycle: nonce dropped, overflow set (sticky), contents unchanged.
REQ-023 Simultaneous push and pop: both performed, count unchanged, no overflow even when full.
REQ-024 Simultaneous push and flush: flush wins, push dropped, overflow unaffected.
REQ-025 Simultaneous overflow-set and overflow-clear write: overflow ends set.
REQ-026 Read/write pointers wrap modulo DEPTH; count width 5 bits.
REQ-027 status_o is registered copy of STATUS fields, updated same cycle as internal state.

Reset
REQ-028 On wb_rst_n low at a clock edge: count 0, pointers 0, overflow 0, CTRL 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0, status_o 16'h2000.
REQ-029 Reset mid-transaction aborts it: no ack issued for a request accepted in the reset cycle; FIFO contents discarded.

Configuration
REQ-030 Macro NONCE_FIFO_IRQ_EN defined: CTRL bit0 irq_en, bit1 ovf_irq_en; irq_o = (irq_en & ~empty) | (ovf_irq_en & overflow), registered.
REQ-031 Macro NONCE_FIFO_IRQ_EN undefined: CTRL reads 0, writes ignored, irq_o tied 0.

Verification
REQ-032 Reset, read STATUS -> 32'h2000_0000; status_o = 16'h2000; irq_o 0.
REQ-033 Push 32'hDEAD_BEEF, 32'h0000_1234 -> STATUS count 2; two DATA reads return DEADBEEF then 00001234; third read 0, empty set.
REQ-034 Push 9 nonces (DEPTH 8) without reads -> count 8, full, overflow set; reads return first 8 in order; write STATUS 32'h8000_0000 -> overflow 0.
REQ-035 Full FIFO, push coincident with DATA-read ack -> count stays 8, overflow 0, new nonce read last.
REQ-036 NONCE_FIFO_IRQ_EN: CTRL=1, push one nonce -> irq_o high 2 cycles after strobe; pop -> irq_o low; without macro irq_o 0 throughout.
REQ-037 Assert wb_rst_n low during pending DATA read with 3 entries -> no ack, STATUS afterwards 32'h2000_0000.

Source files
------------

// File: rtl/nonce_result_fifo.sv
// Golden-nonce result FIFO with a Wishbone register window (DATA/STATUS/CTRL); ack one cycle after acceptance.
// NONCE_FIFO_IRQ_EN enables the CTRL-gated level interrupt; without it CTRL reads 0 and irq_o is 0.
module nonce_result_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        nonce_valid_i,
  input  logic [31:0] nonce_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] status_o,
  output logic        irq_o
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count, count_nxt;
  logic          overflow, overflow_nxt;
  logic [1:0]    ctrl;

  logic [31:0] off, rd_dat;
  logic        in_win, accept, empty, full;
  logic        pop, push, flush, ovf_clr, ovf_set, ctrl_wr;
  logic        unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[30:1], ctrl_wr};

  always_comb begin
    off     = wbs_adr_i - ADDR_BASE;
    in_win  = (off[31:8] == 24'h0);
    accept  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & in_win;
    empty   = (count == 5'd0);
    full    = (count == DEPTH_C);
    pop     = 1'b0;
    flush   = 1'b0;
    ovf_clr = 1'b0;
    ctrl_wr = 1'b0;
    rd_dat  = 32'h0;
    if (accept) begin
      case (off[7:0])
        8'h00: if (!wbs_we_i && !empty) begin
          pop    = 1'b1;
          rd_dat = mem[rd_ptr];
        end
        8'h04: if (wbs_we_i) begin
          flush   = wbs_dat_i[0];
          ovf_clr = wbs_dat_i[31];
        end else begin
          rd_dat = {overflow, full, empty, 24'h0, count};
        end
        8'h08: if (wbs_we_i) ctrl_wr = 1'b1;
               else          rd_dat  = {30'h0, ctrl};
        default: ;
      endcase
    end
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push         = nonce_valid_i & ~flush & (~full | pop);
    ovf_set      = nonce_valid_i & ~flush & full & ~pop;
    count_nxt    = flush ? 5'd0 : (count + 5'(push) - 5'(pop));
    overflow_nxt = ovf_set | (overflow & ~ovf_clr);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 5'd0;
      overflow  <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      status_o  <= 16'h2000;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      wbs_ack_o <= accept;
      wbs_dat_o <= rd_dat;
      status_o  <= {overflow_nxt, count_nxt == DEPTH_C, count_nxt == 5'd0, 8'h00, count_nxt};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= nonce_i;
  end

`ifdef NONCE_FIFO_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      ctrl  <= 2'b00;
      irq_o <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= wbs_dat_i[1:0];
      irq_o <= (ctrl[0] & ~empty) | (ctrl[1] & overflow);
    end
  end
`else
  assign ctrl  = 2'b00;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_nonce_result_fifo.sv
// Randomized bench for nonce_result_fifo: queue-based reference model, scoreboard of expected read data.
module tb_nonce_result_fifo;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0100;
`ifdef NONCE_FIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        nonce_valid_i = 1'b0;
  logic [31:0] nonce_i = 32'h0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] status_o;
  logic        irq_o;

  nonce_result_fifo #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n(wb_rst_n),
    .nonce_valid_i(nonce_valid_i), .nonce_i(nonce_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .status_o(status_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: contents as a queue, plus the sticky flag and control bits.
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  bit          ovf_m = 1'b0;
  bit [1:0]    ctrl_m = 2'b00;
  bit          ack_pending = 1'b0;
  bit          irq_pred = 1'b0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs from the previous edge, drive this cycle, advance the model.
  task automatic step(input bit rst, input bit nv, input logic [31:0] nonce,
                      input bit req, input logic [31:0] adr, input bit we, input logic [31:0] wdat);
    logic [31:0] off, rdat;
    bit acc, flush, clr;
    int n;
    @(negedge clk);
    if (chk_en) begin
      n = q.size();
      chk("status_o", {16'h0, status_o},
          {16'h0, ovf_m, n == DEPTH, n == 0, 8'h00, 5'(n)});
      chk("irq_o", {31'h0, irq_o}, {31'h0, irq_pred});
      chk("ack", {31'h0, wbs_ack_o}, {31'h0, ack_pending});
    end
    wb_rst_n      = !rst;
    nonce_valid_i = nv;
    nonce_i       = nonce;
    wbs_cyc_i     = req;
    wbs_stb_i     = req;
    wbs_we_i      = we;
    wbs_adr_i     = adr;
    wbs_dat_i     = wdat;
    wbs_sel_i     = 4'($urandom_range(0, 15));

    irq_pred = !rst && IRQ && ((ctrl_m[0] && q.size() > 0) || (ctrl_m[1] && ovf_m));
    off = adr - BASE;
    acc = req && !ack_pending && !rst && (off < 32'd256);
    ack_pending = acc;
    flush = 1'b0;
    clr   = 1'b0;
    rdat  = 32'h0;
    if (rst) begin
      q.delete();
      ovf_m  = 1'b0;
      ctrl_m = 2'b00;
    end else begin
      if (acc) begin
        if (off == 32'h0 && !we && q.size() > 0) begin
          rdat = q.pop_front();
        end else if (off == 32'h4) begin
          if (we) begin
            flush = wdat[0];
            clr   = wdat[31];
          end else begin
            rdat = {ovf_m, q.size() == DEPTH, q.size() == 0, 24'h0, 5'(q.size())};
          end
        end else if (off == 32'h8) begin
          if (we) begin
            if (IRQ) ctrl_m = wdat[1:0];
          end else begin
            rdat = {30'h0, ctrl_m};
          end
        end
        exp_q.push_back(rdat);
      end
      if (clr) ovf_m = 1'b0;
      if (flush) q.delete();
      else if (nv) begin
        if (q.size() < DEPTH) q.push_back(nonce);
        else ovf_m = 1'b1;
      end
    end
    if (rst) chk_en = 1'b1;
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic bus(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                     input bit nv = 0, input logic [31:0] nonce = 0);
    step(0, nv, nonce, 1, adr, we, wdat);
    idle(1);
  endtask

  task automatic push(input logic [31:0] nonce);
    step(0, 1, nonce, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: each ack pops one expected read word.
  always @(negedge clk) begin
    if (chk_en) begin
      if (wbs_ack_o) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'h1, 32'h0);
        else chk("wb_rdata", wbs_dat_o, exp_q.pop_front());
      end else begin
        chk("rdata_idle", wbs_dat_o, 32'h0);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int r, k;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Reset state and STATUS read
    bus(BASE + 4, 0, 0);
    // Two pushes, three reads, then status
    push(32'hDEAD_BEEF);
    push(32'h0000_1234);
    bus(BASE + 4, 0, 0);
    repeat (3) bus(BASE, 0, 0);
    bus(BASE + 4, 0, 0);
    // Overflow with nine pushes, drain, then clear overflow
    for (int i = 0; i < 9; i++) push(32'hA000_0000 + i);
    bus(BASE + 4, 0, 0);
    repeat (8) bus(BASE, 0, 0);
    bus(BASE + 4, 1, 32'h8000_0000);
    bus(BASE + 4, 0, 0);
    // Full FIFO: push coincident with a pop, on the accept cycle and on the ack cycle
    for (int i = 0; i < 8; i++) push(32'hB000_0000 + i);
    bus(BASE, 0, 0, 1, 32'hC0FF_EE01);
    step(0, 0, 0, 1, BASE, 0, 0);
    push(32'hC0FF_EE02);
    bus(BASE + 4, 0, 0);
    repeat (9) bus(BASE, 0, 0);
    // Overflow set and clear in the same cycle; then flush with a coincident push
    for (int i = 0; i < 8; i++) push(32'hD000_0000 + i);
    bus(BASE + 4, 1, 32'h8000_0000, 1, 32'hDEAD_0001);
    bus(BASE + 4, 1, 32'h0000_0001, 1, 32'hDEAD_0002);
    bus(BASE + 4, 0, 0);
    bus(BASE + 4, 1, 32'h8000_0000);
    // Interrupt enable and overflow interrupt
    bus(BASE + 8, 1, 32'h0000_0001);
    bus(BASE + 8, 0, 0);
    push(32'h1111_2222);
    idle(3);
    bus(BASE, 0, 0);
    idle(2);
    bus(BASE + 8, 1, 32'h0000_0002);
    for (int i = 0; i < 9; i++) push(32'hE000_0000 + i);
    idle(2);
    bus(BASE + 4, 1, 32'h8000_0001);
    bus(BASE + 8, 1, 32'h0);
    // Window edges and unmapped offsets
    bus(BASE + 32'h10, 0, 0);
    bus(BASE + 32'hFC, 1, 32'hFFFF_FFFF);
    bus(BASE, 1, 32'h1234_5678);
    step(0, 0, 0, 1, BASE + 32'h100, 0, 0);
    step(0, 0, 0, 1, BASE - 4, 0, 0);
    idle(2);
    // Reset during a pending DATA read with three entries
    for (int i = 0; i < 3; i++) push(32'hF000_0000 + i);
    step(1, 0, 0, 1, BASE, 0, 0);
    idle(2);
    bus(BASE + 4, 0, 0);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      k = $urandom_range(0, 9);
      d = $urandom;
      case (k)
        0, 1, 2, 3: a = BASE;
        4:          a = BASE + 4;
        5: begin
          a = BASE + 4;
          d = {($urandom_range(0, 7) == 0), d[30:1], ($urandom_range(0, 9) == 0)};
        end
        6, 7:       a = BASE + 8;
        8:          a = BASE + {22'h0, 8'($urandom_range(3, 63)), 2'b00};
        default:    a = ($urandom_range(0, 1) == 1) ? BASE + 32'h100 + $urandom_range(0, 255)
                                                    : BASE - $urandom_range(1, 255);
      endcase
      step(r < 3, $urandom_range(0, 99) < 45, $urandom, r < 450, a,
           (k == 5 || k == 6 || (k == 8 && d[0])), d);
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
